// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control path.
// Ports are fixed at three; the header address occupies byte[1:0].
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS   = 3'd0,
        LOAD_FIRST_DATA  = 3'd1,
        LOAD_DATA        = 3'd2,
        FIFO_FULL_STATE  = 3'd3,
        LOAD_AFTER_FULL  = 3'd4,
        LOAD_PARITY      = 3'd5,
        CHECK_PARITY_ERR = 3'd6,
        WAIT_TILL_EMPTY  = 3'd7
    } state_t;

endpackage

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, then sequences header,
// payload and parity loading into the selected output FIFO.
module router_fsm
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] datain,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    output logic              busy,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg
);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_reg;

    // Padded to four entries so the invalid address indexes a constant 0.
    logic [3:0] empty_vec;
    logic [3:0] soft_reset_vec;

    assign empty_vec      = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_reset_vec = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

    logic addr_ok;
    assign addr_ok = pkt_valid && (datain != ADDR_INVALID);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= DECODE_ADDRESS;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE_ADDRESS && addr_ok) begin
                addr_reg <= datain;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        full_state    = 1'b0;
        laf_state     = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b1;

        case (state_reg)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
                if (addr_ok) begin
                    state_next = empty_vec[datain] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: begin
                lfd_state  = 1'b1;
                state_next = LOAD_DATA;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
                // A full FIFO takes precedence over the end of the packet.
                if (fifo_full) begin
                    state_next = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_next = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                if (!fifo_full) begin
                    state_next = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                if (parity_done) begin
                    state_next = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_next = LOAD_PARITY;
                end else begin
                    state_next = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                state_next    = CHECK_PARITY_ERR;
            end
            CHECK_PARITY_ERR: begin
                rst_int_reg = 1'b1;
                state_next  = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_vec[addr_reg]) begin
                    state_next = LOAD_FIRST_DATA;
                end
            end
            default: begin
                state_next = DECODE_ADDRESS;
            end
        endcase

        // The destination's soft reset abandons the packet from any busy phase.
        if (state_reg != DECODE_ADDRESS && soft_reset_vec[addr_reg]) begin
            state_next = DECODE_ADDRESS;
        end
    end

endmodule
